memory_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for the single-port 8-bit data memory (write-enable, address, data-in, data-out; combinational read).
- Serialises read/write transactions from requester 0 (CPU datapath) and requester 1 (loader/debug port).
- Holds the memory's address and write data stable around a one-cycle write strobe, and returns read data with a per-requester acknowledge.
- Sits between the requesters and the memory instance; it is the memory's only driver.

---
 rtl/memory_arbiter_pkg.sv | 26 ++
 rtl/memory_arbiter_rr_arb2.sv | 31 +++
 rtl/memory_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_pkg
// Purpose  : Shared constants for the data-memory arbiter: default bus
//            geometry, requester indices and sequencer state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

  // Default geometry of the single-port data memory
  localparam int C_ADDR_W = 8;
  localparam int C_DATA_W = 8;
  localparam int C_DEPTH  = 8;

  // Requester indices (also the encoding of the owner / last-grant flops)
  localparam logic c_REQ_CPU  = 1'b0;
  localparam logic c_REQ_LOAD = 1'b1;

  // Sequencer states
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;

endpackage : memory_arbiter_pkg
`default_nettype wire

// File: rtl/memory_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin picker. A lone requester
//            always wins; under contention the requester that was NOT granted
//            last time wins.
// Ports    : i_req0, i_req1   - request lines
//            i_last_grant     - index of the previously granted requester
//            o_valid          - at least one request is present
//            o_winner         - index of the selected requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import memory_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  logic w_both;

  assign w_both   = i_req0 & i_req1;
  assign o_valid  = i_req0 | i_req1;
  assign o_winner = w_both ? ~i_last_grant
                           : (i_req1 ? c_REQ_LOAD : c_REQ_CPU);

endmodule : rr_arb2
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Round-robin arbiter and sequencer in front of the single-port
//            data memory. Serialises read/write commands from the CPU
//            datapath (requester 0) and the loader/debug port (requester 1).
//            Each transaction takes IDLE -> ACCESS -> RESP, one cycle each.
// Ports    : clk, rst                 - clock, async active-high reset
//            i_req*/i_we*/i_addr*/i_wdata* - requester commands
//            o_ack0, o_ack1           - one-cycle completion pulses
//            o_rdata, o_err           - read data / out-of-range, with ack
//            o_busy                   - sequencer not idle
//            o_mem_we, o_mem_address, o_mem_data_in, i_mem_data_out
//                                     - memory port (combinational read)
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_we;
  logic              r_oob;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data_in;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_valid;
  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_oob;

  rr_arb2 u_rr_arb2 (
    .i_req0       (i_req0),
    .i_req1       (i_req1),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  // Command of the requester that wins arbitration this cycle
  assign w_sel_we    = (w_winner == c_REQ_LOAD) ? i_we1    : i_we0;
  assign w_sel_addr  = (w_winner == c_REQ_LOAD) ? i_addr1  : i_addr0;
  assign w_sel_wdata = (w_winner == c_REQ_LOAD) ? i_wdata1 : i_wdata0;
  // Range check done once at grant time; the latched flag then gates the
  // write strobe, the read data and the error flag.
  assign w_sel_oob   = ({1'b0, w_sel_addr} >= c_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_IDLE;
      r_last_grant  <= c_REQ_LOAD;  // CPU wins the first contention
      r_owner       <= c_REQ_CPU;
      r_we          <= 1'b0;
      r_oob         <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_valid) begin
            r_owner       <= w_winner;
            r_last_grant  <= w_winner;
            r_we          <= w_sel_we;
            r_oob         <= w_sel_oob;
            r_mem_address <= w_sel_addr;
            r_mem_data_in <= w_sel_wdata;
            r_state       <= c_ST_ACCESS;
          end
        end
        c_ST_ACCESS: begin
          // Writes and out-of-range accesses return zero
          r_rdata <= (r_we || r_oob) ? '0 : i_mem_data_out;
          r_err   <= r_oob;
          r_state <= c_ST_RESP;
        end
        c_ST_RESP: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Strobe and acks decode straight from the state so that an asynchronous
  // reset removes them in the same instant, and the strobe can only exist
  // for the single ACCESS cycle.
  assign o_mem_we      = (r_state == c_ST_ACCESS) & r_we & ~r_oob;
  assign o_ack0        = (r_state == c_ST_RESP) & (r_owner == c_REQ_CPU);
  assign o_ack1        = (r_state == c_ST_RESP) & (r_owner == c_REQ_LOAD);
  assign o_busy        = (r_state != c_ST_IDLE);
  assign o_mem_address = r_mem_address;
  assign o_mem_data_in = r_mem_data_in;
  assign o_rdata       = r_rdata;
  assign o_err         = r_err;

endmodule : memory_arbiter
`default_nettype wire
